xif_coproc_mux: RTL and testbench
=================================

Name: xif_coproc_mux

Overview:
- Parametrised eXtension-interface (XIF) fan-out block that lets one core issue port serve NUM_COPROC coprocessors (FPU subsystem, accelerators).
- Broadcasts issue requests to every coprocessor and tracks which coprocessor accepted each instruction ID.
- Routes commits only to the owning coprocessor.
- Arbitrates coprocessor results round-robin into one registered result channel toward the core.

Parameters:
- NUM_COPROC, 2, number of attached coprocessors (2..8)
- ID_WIDTH, 4, XIF instruction ID width; owner table has 2**ID_WIDTH entries
- RES_W, 64, packed width of one result payload (id, rd, data, we, exc fields, opaque here)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- issue_valid_i  in  1  core issue request valid
- issue_ready_o  out  1  AND of all cp_issue_ready_i
- issue_id_i  in  ID_WIDTH  ID of issued instruction
- issue_accept_o  out  1  OR of cp_issue_accept_i
- cp_issue_valid_o  out  NUM_COPROC  per-coprocessor issue valid (broadcast)
- cp_issue_ready_i  in  NUM_COPROC  per-coprocessor issue ready
- cp_issue_accept_i  in  NUM_COPROC  per-coprocessor accept response
- commit_valid_i  in  1  core commit valid
- commit_id_i  in  ID_WIDTH  committed ID
- commit_kill_i  in  1  kill flag of commit
- cp_commit_valid_o  out  NUM_COPROC  commit forwarded to owner only
- cp_commit_kill_o  out  1  registered-free copy of commit_kill_i
- cp_result_valid_i  in  NUM_COPROC  coprocessor result valid
- cp_result_ready_o  out  NUM_COPROC  coprocessor result ready
- cp_result_i  in  NUM_COPROC*RES_W  coprocessor results, index k at bits [k*RES_W +: RES_W]
- result_valid_o  out  1  registered result valid to core
- result_ready_i  in  1  core result ready
- result_o  out  RES_W  registered result payload
- multi_accept_o  out  1  sticky error: more than one coprocessor accepted the same issue

Behaviour:
- Reset (async, rst_i=1): owner table all invalid; result_valid_o=0; result_o=0; RR pointer=0; multi_accept_o=0. Combinational outputs follow inputs.
- Issue:
  - cp_issue_valid_o[k]=issue_valid_i for all k.
  - Handshake fires when issue_valid_i && issue_ready_o.
  - On fire with any accept, owner[issue_id_i] <= {valid=1, idx=lowest accepting k}.
  - If popcount(accept)>1: multi_accept_o set (sticky until reset); lowest index still wins.
  - No accept: table unchanged.
- Commit:
  - When commit_valid_i and owner[commit_id_i].valid: cp_commit_valid_o[idx]=1 in the same cycle; all other bits are 0.
  - Entry is cleared on the next edge, kill or not.
  - Unknown ID: no forwarding, no error.
  - Simultaneous issue fire and commit on the same ID: commit uses the old entry; the issue write wins (entry valid with new owner).
- Result (1-cycle latency):
  - Output register loads when (!result_valid_o || result_ready_i) and any cp_result_valid_i.
  - Grant is the first requester at or after the RR pointer, wrapping modulo NUM_COPROC.
  - cp_result_ready_o[grant]=load; all other bits are 0.
  - On load, pointer <= grant+1 (wraps to 0 after NUM_COPROC-1).
  - Output drains when result_ready_i with no new request: result_valid_o <= 0.
  - Back-to-back throughput is 1 result/cycle when result_ready_i is held high.
  - result_o holds while valid && !ready.
- Reset mid-operation: all in-flight ownership and any pending output result are discarded.

Optional Feature:
- Macro XIF_COPROC_MUX_STATS_EN.
- Defined: adds output port accept_cnt_o (NUM_COPROC*16). Each coprocessor's 16-bit counter increments on every issue fire whose winning owner is that coprocessor, saturates at 16'hFFFF, and resets to 0.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package xif_coproc_mux_pkg:
  - owner_entry_t {logic valid; logic [2:0] idx}
  - MAX_COPROC=8
  - STAT_W=16
- Sub-module xif_rr_arbiter (NUM_REQ param): request vector in, one-hot grant out, pointer update on advance_i. Reused for any future multi-master XIF block.

Test Plan:
- Issue ID 3, accept only from coprocessor 1 → owner[3]={1,1}. Commit id 3 with kill=0 → cp_commit_valid_o=2'b10 for one cycle, then entry cleared. Second commit of id 3 → 2'b00.
- Issue with cp_issue_ready_i=2'b01 → issue_ready_o=0, no table write. Then ready=2'b11 → fires.
- Both coprocessors accept ID 5 → owner idx=0, multi_accept_o=1 and stays 1 until rst_i.
- Both cp_result_valid_i held high, result_ready_i=1 → grants alternate 0,1,0,1, one result per cycle, result_o matches the granted slice one cycle later.
- result_ready_i=0 for 3 cycles with valid result → result_o stable, cp_result_ready_o=0. Ready rises → drain and reload in the same cycle.
- Assert rst_i mid-stream with valid output and owner entries → result_valid_o=0 immediately, later commits forward nothing. With STATS_EN, 65537 accepts to coprocessor 0 → accept_cnt_o[15:0]=16'hFFFF.

Source files
------------

// File: rtl/xif_coproc_mux_pkg.sv
// Shared types and constants for the XIF coprocessor fan-out block.
package xif_coproc_mux_pkg;

    localparam int MAX_COPROC = 8;
    localparam int STAT_W     = 16;

    // One owner-table slot per instruction ID: which coprocessor took it.
    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } owner_entry_t;

endpackage

// File: rtl/xif_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves just past the grant whenever advance_i is high.
module xif_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] gnt_idx;
    logic             found;

    always_comb begin
        grant_o = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[(int'(ptr_q) + i) % NUM_REQ]) begin
                found = 1'b1;
                grant_o[(int'(ptr_q) + i) % NUM_REQ] = 1'b1;
                gnt_idx = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (advance_i && found) begin
            ptr_q <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/xif_coproc_mux.sv
// XIF fan-out: broadcasts issues, tracks the owning coprocessor per ID, routes
// commits to the owner and arbitrates results. XIF_COPROC_MUX_STATS_EN adds accept_cnt_o.
module xif_coproc_mux
    import xif_coproc_mux_pkg::*;
#(
    parameter int NUM_COPROC = 2,
    parameter int ID_WIDTH   = 4,
    parameter int RES_W      = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        issue_valid_i,
    output logic                        issue_ready_o,
    input  logic [ID_WIDTH-1:0]         issue_id_i,
    output logic                        issue_accept_o,
    output logic [NUM_COPROC-1:0]       cp_issue_valid_o,
    input  logic [NUM_COPROC-1:0]       cp_issue_ready_i,
    input  logic [NUM_COPROC-1:0]       cp_issue_accept_i,
    input  logic                        commit_valid_i,
    input  logic [ID_WIDTH-1:0]         commit_id_i,
    input  logic                        commit_kill_i,
    output logic [NUM_COPROC-1:0]       cp_commit_valid_o,
    output logic                        cp_commit_kill_o,
    input  logic [NUM_COPROC-1:0]       cp_result_valid_i,
    output logic [NUM_COPROC-1:0]       cp_result_ready_o,
    input  logic [NUM_COPROC*RES_W-1:0] cp_result_i,
    output logic                        result_valid_o,
    input  logic                        result_ready_i,
    output logic [RES_W-1:0]            result_o,
    output logic                        multi_accept_o
`ifdef XIF_COPROC_MUX_STATS_EN
    ,
    output logic [NUM_COPROC*STAT_W-1:0] accept_cnt_o
`endif
);

    owner_entry_t          owner_q [2**ID_WIDTH];
    owner_entry_t          commit_entry;
    logic                  commit_hit;
    logic                  issue_win;
    logic [2:0]            acc_idx;
    logic                  result_load;
    logic [NUM_COPROC-1:0] grant;
    logic [RES_W-1:0]      res_mux;

    assign issue_ready_o    = &cp_issue_ready_i;
    assign issue_accept_o   = |cp_issue_accept_i;
    assign cp_issue_valid_o = {NUM_COPROC{issue_valid_i}};
    assign issue_win        = issue_valid_i && issue_ready_o && issue_accept_o;
    assign cp_commit_kill_o = commit_kill_i;

    // Descending scan so the lowest accepting index is the one left standing.
    always_comb begin
        acc_idx = '0;
        for (int k = NUM_COPROC - 1; k >= 0; k--) begin
            if (cp_issue_accept_i[k]) acc_idx = 3'(k);
        end
    end

    assign commit_entry = owner_q[commit_id_i];
    assign commit_hit   = commit_valid_i && commit_entry.valid;

    always_comb begin
        cp_commit_valid_o = '0;
        for (int k = 0; k < NUM_COPROC; k++) begin
            cp_commit_valid_o[k] = commit_hit && (commit_entry.idx == 3'(k));
        end
    end

    // The issue write is placed last so it overrides a same-ID commit clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2**ID_WIDTH; i++) owner_q[i] <= '0;
            multi_accept_o <= 1'b0;
        end else begin
            if (commit_hit) owner_q[commit_id_i] <= '0;
            if (issue_win) owner_q[issue_id_i] <= '{valid: 1'b1, idx: acc_idx};
            if (issue_win && ($countones(cp_issue_accept_i) > 1)) multi_accept_o <= 1'b1;
        end
    end

    assign result_load = (!result_valid_o || result_ready_i) && (|cp_result_valid_i);

    xif_rr_arbiter #(.NUM_REQ(NUM_COPROC)) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (cp_result_valid_i),
        .advance_i (result_load),
        .grant_o   (grant)
    );

    assign cp_result_ready_o = result_load ? grant : '0;

    always_comb begin
        res_mux = '0;
        for (int k = 0; k < NUM_COPROC; k++) begin
            if (grant[k]) res_mux = cp_result_i[k*RES_W +: RES_W];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_valid_o <= 1'b0;
            result_o       <= '0;
        end else if (result_load) begin
            result_valid_o <= 1'b1;
            result_o       <= res_mux;
        end else if (result_ready_i) begin
            result_valid_o <= 1'b0;
        end
    end

`ifdef XIF_COPROC_MUX_STATS_EN
    logic [STAT_W-1:0] cnt_q [NUM_COPROC];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_COPROC; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_COPROC; k++) begin
                if (issue_win && (acc_idx == 3'(k)) && (cnt_q[k] != '1)) begin
                    cnt_q[k] <= cnt_q[k] + STAT_W'(1);
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_COPROC; k++) begin : g_cnt_out
        assign accept_cnt_o[k*STAT_W +: STAT_W] = cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_xif_coproc_mux.sv
// Self-checking bench for xif_coproc_mux: per-cycle reference model plus directed literal checks.
module tb_xif_coproc_mux;

    localparam int N  = 2;
    localparam int IW = 4;
    localparam int RW = 64;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            issue_valid_i = 1'b0;
    logic            issue_ready_o;
    logic [IW-1:0]   issue_id_i = '0;
    logic            issue_accept_o;
    logic [N-1:0]    cp_issue_valid_o;
    logic [N-1:0]    cp_issue_ready_i = '1;
    logic [N-1:0]    cp_issue_accept_i = '0;
    logic            commit_valid_i = 1'b0;
    logic [IW-1:0]   commit_id_i = '0;
    logic            commit_kill_i = 1'b0;
    logic [N-1:0]    cp_commit_valid_o;
    logic            cp_commit_kill_o;
    logic [N-1:0]    cp_result_valid_i = '0;
    logic [N-1:0]    cp_result_ready_o;
    logic [N*RW-1:0] cp_result_i = '0;
    logic            result_valid_o;
    logic            result_ready_i = 1'b0;
    logic [RW-1:0]   result_o;
    logic            multi_accept_o;
`ifdef XIF_COPROC_MUX_STATS_EN
    logic [N*16-1:0] accept_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xif_coproc_mux #(.NUM_COPROC(N), .ID_WIDTH(IW), .RES_W(RW)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_id_i        (issue_id_i),
        .issue_accept_o    (issue_accept_o),
        .cp_issue_valid_o  (cp_issue_valid_o),
        .cp_issue_ready_i  (cp_issue_ready_i),
        .cp_issue_accept_i (cp_issue_accept_i),
        .commit_valid_i    (commit_valid_i),
        .commit_id_i       (commit_id_i),
        .commit_kill_i     (commit_kill_i),
        .cp_commit_valid_o (cp_commit_valid_o),
        .cp_commit_kill_o  (cp_commit_kill_o),
        .cp_result_valid_i (cp_result_valid_i),
        .cp_result_ready_o (cp_result_ready_o),
        .cp_result_i       (cp_result_i),
        .result_valid_o    (result_valid_o),
        .result_ready_i    (result_ready_i),
        .result_o          (result_o),
        .multi_accept_o    (multi_accept_o)
`ifdef XIF_COPROC_MUX_STATS_EN
        ,
        .accept_cnt_o      (accept_cnt_o)
`endif
    );

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner per ID (-1 = none), RR pointer, output register.
    int            m_own [2**IW];
    int            m_ptr;
    bit            m_rv;
    logic [RW-1:0] m_res;
    bit            m_multi;

    always @(negedge clk) begin
        int g, nacc, first_acc;
        bit all_rdy, any_req, ld;
        logic [N-1:0] e_cv, e_rr;
        if (rst_i) begin
            foreach (m_own[i]) m_own[i] = -1;
            m_ptr = 0; m_rv = 0; m_res = '0; m_multi = 0;
        end
        all_rdy = 1; nacc = 0; first_acc = -1; any_req = 0; g = -1;
        for (int k = 0; k < N; k++) begin
            if (!cp_issue_ready_i[k]) all_rdy = 0;
            if (cp_issue_accept_i[k]) begin
                nacc++;
                if (first_acc < 0) first_acc = k;
            end
            if (cp_result_valid_i[k]) any_req = 1;
        end
        e_cv = '0;
        if (commit_valid_i && m_own[commit_id_i] >= 0) e_cv[m_own[commit_id_i]] = 1'b1;
        for (int off = 0; off < N; off++)
            if (g < 0 && cp_result_valid_i[(m_ptr + off) % N]) g = (m_ptr + off) % N;
        ld = (!m_rv || result_ready_i) && any_req;
        e_rr = '0;
        if (ld) e_rr[g] = 1'b1;

        chk("issue_ready", RW'(issue_ready_o), RW'(all_rdy));
        chk("issue_accept", RW'(issue_accept_o), RW'(nacc > 0));
        chk("cp_issue_valid", RW'(cp_issue_valid_o), issue_valid_i ? RW'({N{1'b1}}) : RW'(0));
        chk("cp_commit_valid", RW'(cp_commit_valid_o), RW'(e_cv));
        chk("cp_commit_kill", RW'(cp_commit_kill_o), RW'(commit_kill_i));
        chk("cp_result_ready", RW'(cp_result_ready_o), RW'(e_rr));
        chk("result_valid", RW'(result_valid_o), RW'(m_rv));
        chk("result", result_o, m_res);
        chk("multi_accept", RW'(multi_accept_o), RW'(m_multi));

        if (!rst_i) begin
            if (commit_valid_i) m_own[commit_id_i] = -1;
            if (issue_valid_i && all_rdy && nacc > 0) begin
                m_own[issue_id_i] = first_acc;
                if (nacc > 1) m_multi = 1;
            end
            if (ld) begin
                m_rv = 1; m_res = cp_result_i[g*RW +: RW]; m_ptr = (g + 1) % N;
            end else if (result_ready_i) begin
                m_rv = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid_i = 0; cp_issue_accept_i = '0; cp_issue_ready_i = '1;
        commit_valid_i = 0; commit_kill_i = 0;
    endtask

    initial begin
        // reset state
        @(negedge clk);
        chk("rst_result_valid", RW'(result_valid_o), 0);
        chk("rst_result", result_o, 0);
        chk("rst_multi", RW'(multi_accept_o), 0);
        tick(); rst_i = 0;

        // issue ID 3 accepted by coprocessor 1 only
        tick(); issue_valid_i = 1; issue_id_i = 4'd3; cp_issue_accept_i = 2'b10;
        @(negedge clk);
        chk("t1_ready", RW'(issue_ready_o), 1);
        chk("t1_cp_valid", RW'(cp_issue_valid_o), RW'(2'b11));
        tick(); idle();
        chk("t1_model_owner", RW'(m_own[3]), 1);
        commit_valid_i = 1; commit_id_i = 4'd3;
        @(negedge clk);
        chk("t1_commit", RW'(cp_commit_valid_o), RW'(2'b10));
        tick();
        @(negedge clk);
        chk("t1_commit_again", RW'(cp_commit_valid_o), RW'(2'b00));

        // not all coprocessors ready: no fire, no table write
        tick(); idle(); issue_valid_i = 1; issue_id_i = 4'd7; cp_issue_ready_i = 2'b01; cp_issue_accept_i = 2'b01;
        @(negedge clk);
        chk("t2_not_ready", RW'(issue_ready_o), 0);
        tick(); idle(); commit_valid_i = 1; commit_id_i = 4'd7;
        @(negedge clk);
        chk("t2_no_write", RW'(cp_commit_valid_o), RW'(2'b00));
        tick(); idle(); issue_valid_i = 1; issue_id_i = 4'd7; cp_issue_accept_i = 2'b01;
        @(negedge clk);
        chk("t2_ready", RW'(issue_ready_o), 1);
        tick(); idle(); commit_valid_i = 1; commit_id_i = 4'd7; commit_kill_i = 1;
        @(negedge clk);
        chk("t2_commit", RW'(cp_commit_valid_o), RW'(2'b01));
        chk("t2_kill", RW'(cp_commit_kill_o), 1);

        // both accept ID 5: lowest wins, sticky error
        tick(); idle(); issue_valid_i = 1; issue_id_i = 4'd5; cp_issue_accept_i = 2'b11;
        @(negedge clk);
        chk("t3_multi_before", RW'(multi_accept_o), 0);
        tick(); idle(); commit_valid_i = 1; commit_id_i = 4'd5;
        @(negedge clk);
        chk("t3_multi_set", RW'(multi_accept_o), 1);
        chk("t3_owner0", RW'(cp_commit_valid_o), RW'(2'b01));

        // issue and commit of the same ID in one cycle
        tick(); idle(); issue_valid_i = 1; issue_id_i = 4'd9; cp_issue_accept_i = 2'b10;
        tick(); idle(); issue_valid_i = 1; issue_id_i = 4'd9; cp_issue_accept_i = 2'b01;
        commit_valid_i = 1; commit_id_i = 4'd9;
        @(negedge clk);
        chk("t4_old_owner", RW'(cp_commit_valid_o), RW'(2'b10));
        tick(); idle(); commit_valid_i = 1; commit_id_i = 4'd9;
        @(negedge clk);
        chk("t4_new_owner", RW'(cp_commit_valid_o), RW'(2'b01));

        // results: both requesting, core always ready -> alternate 0,1,0,1
        tick(); idle(); cp_result_valid_i = 2'b11; result_ready_i = 1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            cp_result_i = {64'hB0 + 64'(c), 64'hA0 + 64'(c)};
            @(negedge clk);
            chk("t5_grant", RW'(cp_result_ready_o), (c % 2 == 0) ? RW'(2'b01) : RW'(2'b10));
            if (c > 0) chk("t5_result", result_o, (c % 2 == 1) ? 64'hA0 + 64'(c - 1) : 64'hB0 + 64'(c - 1));
        end

        // core stalls for 3 cycles
        for (int c = 0; c < 3; c++) begin
            tick(); result_ready_i = 0; cp_result_i = {64'hC1, 64'hC0};
            @(negedge clk);
            chk("t6_hold", result_o, 64'hB3);
            chk("t6_hold_valid", RW'(result_valid_o), 1);
            chk("t6_no_ready", RW'(cp_result_ready_o), RW'(2'b00));
        end
        tick(); result_ready_i = 1;
        @(negedge clk);
        chk("t6_reload_grant", RW'(cp_result_ready_o), RW'(2'b01));
        tick(); cp_result_valid_i = 2'b00;
        @(negedge clk);
        chk("t6_reload", result_o, 64'hC0);
        tick();
        @(negedge clk);
        chk("t6_drained", RW'(result_valid_o), 0);

        // reset mid-operation
        tick(); idle(); issue_valid_i = 1; issue_id_i = 4'd2; cp_issue_accept_i = 2'b10;
        tick(); idle(); cp_result_valid_i = 2'b01; cp_result_i = {64'hD1, 64'hD0}; result_ready_i = 0;
        tick(); cp_result_valid_i = 2'b00;
        @(negedge clk);
        chk("t7_pending", RW'(result_valid_o), 1);
        chk("t7_multi_sticky", RW'(multi_accept_o), 1);
        tick(); rst_i = 1;
        #1;
        chk("t7_rst_valid", RW'(result_valid_o), 0);
        chk("t7_rst_multi", RW'(multi_accept_o), 0);
        tick(); rst_i = 0; commit_valid_i = 1; commit_id_i = 4'd2;
        @(negedge clk);
        chk("t7_no_forward", RW'(cp_commit_valid_o), RW'(2'b00));
        tick(); idle();

`ifdef XIF_COPROC_MUX_STATS_EN
        issue_valid_i = 1; cp_issue_accept_i = 2'b01;
        for (int i = 0; i < 65537; i++) begin
            issue_id_i = IW'(i);
            tick();
        end
        idle();
        @(negedge clk);
        chk("stats_sat0", RW'(accept_cnt_o[15:0]), 64'hFFFF);
        chk("stats_cnt1", RW'(accept_cnt_o[31:16]), 0);
`endif

        tick();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
